// File: rtl/ysyx_22050612_lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, response error codes and FSM states.
package ysyx_22050612_lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_ALIGN   = 2'b01,
    ERR_TIMEOUT = 2'b10
  } err_e;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } state_e;

  // Low address bits that must be zero for a naturally aligned access of the given size.
  function automatic logic [2:0] alignMask(input size_e size);
    case (size)
      SZ_B:    alignMask = 3'b000;
      SZ_H:    alignMask = 3'b001;
      SZ_W:    alignMask = 3'b011;
      default: alignMask = 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_22050612_lsu_if.sv
// Execute-side request/response bundle and data-memory port bundle of the LSU.
interface ysyx_22050612_lsu_req_if #(parameter int XLEN = 64) ();
  logic            req_valid;
  logic            req_ready;
  logic            req_wen;
  logic [1:0]      req_size;
  logic            req_unsigned;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_rdata;
  logic [1:0]      rsp_err;

  modport master (
    output req_valid, req_wen, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wen, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

interface ysyx_22050612_lsu_mem_if #(parameter int XLEN = 64) ();
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_we;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN/8-1:0] mem_wmask;
  logic              mem_rsp_valid;
  logic [XLEN-1:0]   mem_rdata;

  modport master (
    output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_rsp_valid, mem_rdata
  );

  modport slave (
    input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask,
    output mem_req_ready, mem_rsp_valid, mem_rdata
  );
endinterface

// File: rtl/ysyx_22050612_lsu_ext.sv
// Load-lane extraction: shifts the addressed bytes of an aligned word down and sign/zero extends them.
module ysyx_22050612_lsu_ext
  import ysyx_22050612_lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0]           rdata_i,
  input  logic [$clog2(XLEN/8)-1:0] off_i,
  input  size_e                     size_i,
  input  logic                      unsigned_i,
  output logic [XLEN-1:0]           data_o
);

  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] lowMask;
  logic            signBit;

  assign shifted = rdata_i >> {off_i, 3'b000};

  // Full-width accesses keep lowMask all ones, so extension leaves them untouched.
  always_comb begin
    lowMask = '1;
    signBit = shifted[XLEN-1];
    case (size_i)
      SZ_B: begin
        lowMask = XLEN'(8'hFF);
        signBit = shifted[7];
      end
      SZ_H: begin
        lowMask = XLEN'(16'hFFFF);
        signBit = shifted[15];
      end
      SZ_W: begin
        lowMask = XLEN'(32'hFFFF_FFFF);
        signBit = shifted[31];
      end
      default: ;
    endcase
    data_o = shifted & lowMask;
    if (!unsigned_i && signBit) begin
      data_o = data_o | ~lowMask;
    end
  end

endmodule

// File: rtl/ysyx_22050612_lsu.sv
// Multi-cycle load/store unit: one outstanding valid/ready transaction between execute and data memory,
// with misalignment checking and a bounded wait for the memory response.
module ysyx_22050612_lsu
  import ysyx_22050612_lsu_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int TIMEOUT_CYC = 256
) (
  input logic                    clk,
  input logic                    rst_n,
  ysyx_22050612_lsu_req_if.slave req,
  ysyx_22050612_lsu_mem_if.master mem
);

  localparam int MW   = XLEN / 8;
  localparam int OFFW = $clog2(MW);
  localparam int CNTW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  state_e          state_q;
  logic [OFFW-1:0] off_q;
  size_e           size_q;
  logic            wen_q;
  logic            unsigned_q;
  logic [CNTW-1:0] timeoutCnt_q;

  logic            reqReady_q;
  logic            memReqValid_q;
  logic            memWe_q;
  logic [XLEN-1:0] memAddr_q;
  logic [XLEN-1:0] memWdata_q;
  logic [MW-1:0]   memWmask_q;
  logic            rspValid_q;
  logic [XLEN-1:0] rspRdata_q;
  logic [1:0]      rspErr_q;

  size_e           reqSize;
  logic [OFFW-1:0] reqOff;
  logic [2:0]      offExt;
  logic [MW-1:0]   byteMask;
  logic            badReq_d;
  logic [XLEN-1:0] memAddr_d;
  logic [XLEN-1:0] memWdata_d;
  logic [MW-1:0]   memWmask_d;
  logic [XLEN-1:0] loadData;

  always_comb begin
    reqSize = size_e'(req.req_size);
    reqOff  = req.req_addr[OFFW-1:0];
    offExt  = 3'(reqOff);
    case (reqSize)
      SZ_B:    byteMask = MW'(1'b1);
      SZ_H:    byteMask = MW'(2'b11);
      SZ_W:    byteMask = MW'(4'hF);
      default: byteMask = '1;
    endcase
    badReq_d   = ((offExt & alignMask(reqSize)) != 3'b000) || ((reqSize == SZ_D) && (XLEN == 32));
    memAddr_d  = {req.req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
    memWdata_d = req.req_wdata << {reqOff, 3'b000};
    memWmask_d = req.req_wen ? (byteMask << reqOff) : '1;
  end

  ysyx_22050612_lsu_ext #(
    .XLEN(XLEN)
  ) u_ext (
    .rdata_i   (mem.mem_rdata),
    .off_i     (off_q),
    .size_i    (size_q),
    .unsigned_i(unsigned_q),
    .data_o    (loadData)
  );

  // A response arriving on the final wait cycle takes priority over the timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      off_q         <= '0;
      size_q        <= SZ_B;
      wen_q         <= 1'b0;
      unsigned_q    <= 1'b0;
      timeoutCnt_q  <= '0;
      reqReady_q    <= 1'b1;
      memReqValid_q <= 1'b0;
      memWe_q       <= 1'b0;
      memAddr_q     <= '0;
      memWdata_q    <= '0;
      memWmask_q    <= '0;
      rspValid_q    <= 1'b0;
      rspRdata_q    <= '0;
      rspErr_q      <= ERR_OK;
    end else begin
      case (state_q)
        IDLE: begin
          if (req.req_valid) begin
            off_q      <= reqOff;
            size_q     <= reqSize;
            wen_q      <= req.req_wen;
            unsigned_q <= req.req_unsigned;
            reqReady_q <= 1'b0;
            if (badReq_d) begin
              state_q    <= RESP;
              rspValid_q <= 1'b1;
              rspRdata_q <= '0;
              rspErr_q   <= ERR_ALIGN;
            end else begin
              state_q       <= REQ;
              memReqValid_q <= 1'b1;
              memWe_q       <= req.req_wen;
              memAddr_q     <= memAddr_d;
              memWdata_q    <= memWdata_d;
              memWmask_q    <= memWmask_d;
            end
          end
        end
        REQ: begin
          if (mem.mem_req_ready) begin
            state_q       <= WAIT;
            memReqValid_q <= 1'b0;
            timeoutCnt_q  <= '0;
          end
        end
        WAIT: begin
          if (mem.mem_rsp_valid) begin
            state_q    <= RESP;
            rspValid_q <= 1'b1;
            rspRdata_q <= wen_q ? '0 : loadData;
            rspErr_q   <= ERR_OK;
          end else if ((TIMEOUT_CYC != 0) && (timeoutCnt_q == CNT_LAST)) begin
            state_q    <= RESP;
            rspValid_q <= 1'b1;
            rspRdata_q <= '0;
            rspErr_q   <= ERR_TIMEOUT;
          end else begin
            timeoutCnt_q <= timeoutCnt_q + CNTW'(1);
          end
        end
        RESP: begin
          if (req.rsp_ready) begin
            state_q    <= IDLE;
            rspValid_q <= 1'b0;
            rspRdata_q <= '0;
            rspErr_q   <= ERR_OK;
            reqReady_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req.req_ready     = reqReady_q;
  assign req.rsp_valid     = rspValid_q;
  assign req.rsp_rdata     = rspRdata_q;
  assign req.rsp_err       = rspErr_q;
  assign mem.mem_req_valid = memReqValid_q;
  assign mem.mem_we        = memWe_q;
  assign mem.mem_addr      = memAddr_q;
  assign mem.mem_wdata     = memWdata_q;
  assign mem.mem_wmask     = memWmask_q;

endmodule

// File: tb/tb_ysyx_22050612_lsu.sv
// Self-checking bench for the LSU: vector table with a response scoreboard plus hand-written corner sequences.
module tb_ysyx_22050612_lsu;
  import ysyx_22050612_lsu_pkg::*;

  typedef struct {
    logic        wen;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] memRdata;
    logic        expMem;
    logic [63:0] expAddr;
    logic [63:0] expWdata;
    logic [7:0]  expMask;
    logic [63:0] expRdata;
    logic [1:0]  expErr;
  } vec_t;

  typedef struct packed {
    logic [63:0] rdata;
    logic [1:0]  err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   testsRun = 0;
  int   testsFailed = 0;
  exp_t expQ[$];
  vec_t vecs[14];

  always #5 clk = ~clk;

  ysyx_22050612_lsu_req_if #(.XLEN(64)) reqIf ();
  ysyx_22050612_lsu_mem_if #(.XLEN(64)) memIf ();
  ysyx_22050612_lsu_req_if #(.XLEN(32)) reqIf32 ();
  ysyx_22050612_lsu_mem_if #(.XLEN(32)) memIf32 ();

  ysyx_22050612_lsu #(.XLEN(64), .TIMEOUT_CYC(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (reqIf),
    .mem  (memIf)
  );

  ysyx_22050612_lsu #(.XLEN(32), .TIMEOUT_CYC(16)) dut32 (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (reqIf32),
    .mem  (memIf32)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic issueReq(input logic wen, input logic [1:0] size, input logic uns,
                          input logic [63:0] addr, input logic [63:0] wdata, input string name);
    checkOutput({name, " req_ready idle"}, 64'(reqIf.req_ready), 64'd1);
    reqIf.req_valid    = 1'b1;
    reqIf.req_wen      = wen;
    reqIf.req_size     = size;
    reqIf.req_unsigned = uns;
    reqIf.req_addr     = addr;
    reqIf.req_wdata    = wdata;
    @(negedge clk);
    reqIf.req_valid    = 1'b0;
    checkOutput({name, " req_ready busy"}, 64'(reqIf.req_ready), 64'd0);
  endtask

  task automatic memServe(input logic [63:0] rdata, input string name);
    memIf.mem_req_ready = 1'b1;
    @(negedge clk);
    memIf.mem_req_ready = 1'b0;
    checkOutput({name, " mem_req_valid drop"}, 64'(memIf.mem_req_valid), 64'd0);
    memIf.mem_rsp_valid = 1'b1;
    memIf.mem_rdata     = rdata;
    @(negedge clk);
    memIf.mem_rsp_valid = 1'b0;
    memIf.mem_rdata     = '0;
  endtask

  task automatic popAndCheck(input string name);
    exp_t e;
    if (expQ.size() == 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s scoreboard: got empty queue, expected an entry", name);
    end else begin
      e = expQ.pop_front();
      checkOutput({name, " rsp_rdata"}, reqIf.rsp_rdata, e.rdata);
      checkOutput({name, " rsp_err"}, 64'(reqIf.rsp_err), 64'(e.err));
    end
  endtask

  task automatic consumeRsp(input string name);
    reqIf.rsp_ready = 1'b1;
    @(negedge clk);
    reqIf.rsp_ready = 1'b0;
    checkOutput({name, " rsp_valid cleared"}, 64'(reqIf.rsp_valid), 64'd0);
    checkOutput({name, " req_ready back"}, 64'(reqIf.req_ready), 64'd1);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    string name;
    name = $sformatf("vec%0d", idx);
    expQ.push_back('{rdata: v.expRdata, err: v.expErr});
    issueReq(v.wen, v.size, v.uns, v.addr, v.wdata, name);
    if (v.expMem) begin
      checkOutput({name, " mem_req_valid"}, 64'(memIf.mem_req_valid), 64'd1);
      checkOutput({name, " mem_addr"}, memIf.mem_addr, v.expAddr);
      checkOutput({name, " mem_wdata"}, memIf.mem_wdata, v.expWdata);
      checkOutput({name, " mem_wmask"}, 64'(memIf.mem_wmask), 64'(v.expMask));
      checkOutput({name, " mem_we"}, 64'(memIf.mem_we), 64'(v.wen));
      memServe(v.memRdata, name);
    end else begin
      checkOutput({name, " no mem_req_valid"}, 64'(memIf.mem_req_valid), 64'd0);
    end
    checkOutput({name, " rsp_valid latency"}, 64'(reqIf.rsp_valid), 64'd1);
    popAndCheck(name);
    consumeRsp(name);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    reqIf.req_valid = 1'b0;   reqIf.req_wen = 1'b0;  reqIf.req_size = 2'd0;
    reqIf.req_unsigned = 1'b0; reqIf.req_addr = '0;  reqIf.req_wdata = '0;
    reqIf.rsp_ready = 1'b0;
    memIf.mem_req_ready = 1'b0; memIf.mem_rsp_valid = 1'b0; memIf.mem_rdata = '0;
    reqIf32.req_valid = 1'b0; reqIf32.req_wen = 1'b0; reqIf32.req_size = 2'd0;
    reqIf32.req_unsigned = 1'b0; reqIf32.req_addr = '0; reqIf32.req_wdata = '0;
    reqIf32.rsp_ready = 1'b0;
    memIf32.mem_req_ready = 1'b0; memIf32.mem_rsp_valid = 1'b0; memIf32.mem_rdata = '0;

    //          wen  sz    uns   addr                  wdata                  memRdata               mem   expAddr        expWdata               mask   expRdata               err
    vecs[0]  = '{1'b0, 2'd0, 1'b0, 64'h8000_0003, 64'h0, 64'h0000_0000_8F00_0000, 1'b1, 64'h8000_0000, 64'h0, 8'hFF, 64'hFFFF_FFFF_FFFF_FF8F, 2'b00};
    vecs[1]  = '{1'b0, 2'd2, 1'b1, 64'h8000_0004, 64'h0, 64'h8000_0001_0000_0000, 1'b1, 64'h8000_0000, 64'h0, 8'hFF, 64'h0000_0000_8000_0001, 2'b00};
    vecs[2]  = '{1'b0, 2'd2, 1'b0, 64'h8000_0004, 64'h0, 64'h8000_0001_0000_0000, 1'b1, 64'h8000_0000, 64'h0, 8'hFF, 64'hFFFF_FFFF_8000_0001, 2'b00};
    vecs[3]  = '{1'b1, 2'd1, 1'b0, 64'h8000_0006, 64'h1234, 64'h0, 1'b1, 64'h8000_0000, 64'h1234_0000_0000_0000, 8'hC0, 64'h0, 2'b00};
    vecs[4]  = '{1'b0, 2'd3, 1'b0, 64'h8000_0004, 64'h0, 64'h0, 1'b0, 64'h0, 64'h0, 8'h00, 64'h0, 2'b01};
    vecs[5]  = '{1'b0, 2'd1, 1'b1, 64'h8000_0002, 64'h0, 64'h1122_3344_8899_AABB, 1'b1, 64'h8000_0000, 64'h0, 8'hFF, 64'h0000_0000_0000_8899, 2'b00};
    vecs[6]  = '{1'b0, 2'd1, 1'b0, 64'h8000_0002, 64'h0, 64'h1122_3344_8899_AABB, 1'b1, 64'h8000_0000, 64'h0, 8'hFF, 64'hFFFF_FFFF_FFFF_8899, 2'b00};
    vecs[7]  = '{1'b0, 2'd3, 1'b0, 64'h8000_0008, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 1'b1, 64'h8000_0008, 64'h0, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D, 2'b00};
    vecs[8]  = '{1'b1, 2'd2, 1'b0, 64'h8000_0004, 64'hA5A5_5A5A, 64'h0, 1'b1, 64'h8000_0000, 64'hA5A5_5A5A_0000_0000, 8'hF0, 64'h0, 2'b00};
    vecs[9]  = '{1'b1, 2'd0, 1'b0, 64'h8000_0005, 64'h77, 64'h0, 1'b1, 64'h8000_0000, 64'h0000_7700_0000_0000, 8'h20, 64'h0, 2'b00};
    vecs[10] = '{1'b0, 2'd1, 1'b0, 64'h8000_0001, 64'h0, 64'h0, 1'b0, 64'h0, 64'h0, 8'h00, 64'h0, 2'b01};
    vecs[11] = '{1'b1, 2'd3, 1'b0, 64'h8000_0010, 64'h0102_0304_0506_0708, 64'h0, 1'b1, 64'h8000_0010, 64'h0102_0304_0506_0708, 8'hFF, 64'h0, 2'b00};
    vecs[12] = '{1'b0, 2'd0, 1'b1, 64'h8000_0007, 64'h0, 64'h9A00_0000_0000_0000, 1'b1, 64'h8000_0000, 64'h0, 8'hFF, 64'h0000_0000_0000_009A, 2'b00};
    vecs[13] = '{1'b1, 2'd2, 1'b0, 64'h8000_0002, 64'hFFFF_FFFF, 64'h0, 1'b0, 64'h0, 64'h0, 8'h00, 64'h0, 2'b01};

    @(negedge clk);
    @(negedge clk);
    checkOutput("reset req_ready", 64'(reqIf.req_ready), 64'd1);
    checkOutput("reset rsp_valid", 64'(reqIf.rsp_valid), 64'd0);
    checkOutput("reset mem_req_valid", 64'(memIf.mem_req_valid), 64'd0);
    checkOutput("reset mem_wmask", 64'(memIf.mem_wmask), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i], i);
    end

    // Request stall then response timeout, with a late response that must be dropped.
    expQ.push_back('{rdata: 64'h0, err: 2'b10});
    issueReq(1'b1, 2'd2, 1'b0, 64'h8000_0004, 64'hCAFE_BABE, "tmo");
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("tmo stall%0d mem_req_valid", i), 64'(memIf.mem_req_valid), 64'd1);
      checkOutput($sformatf("tmo stall%0d mem_addr", i), memIf.mem_addr, 64'h8000_0000);
      checkOutput($sformatf("tmo stall%0d mem_wdata", i), memIf.mem_wdata, 64'hCAFE_BABE_0000_0000);
      checkOutput($sformatf("tmo stall%0d mem_wmask", i), 64'(memIf.mem_wmask), 64'hF0);
      @(negedge clk);
    end
    memIf.mem_req_ready = 1'b1;
    @(negedge clk);
    memIf.mem_req_ready = 1'b0;
    n = 0;
    while (reqIf.rsp_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("tmo wait cycles", 64'(n), 64'd8);
    memIf.mem_rsp_valid = 1'b1;
    memIf.mem_rdata     = 64'h5555_AAAA_5555_AAAA;
    @(negedge clk);
    memIf.mem_rsp_valid = 1'b0;
    checkOutput("tmo late rsp_valid held", 64'(reqIf.rsp_valid), 64'd1);
    popAndCheck("tmo");
    consumeRsp("tmo");
    memIf.mem_rsp_valid = 1'b1;
    @(negedge clk);
    memIf.mem_rsp_valid = 1'b0;
    checkOutput("tmo no second rsp", 64'(reqIf.rsp_valid), 64'd0);
    @(negedge clk);
    checkOutput("tmo still idle", 64'(reqIf.req_ready), 64'd1);

    // Response back-pressure: everything held while rsp_ready stays low.
    expQ.push_back('{rdata: 64'h7F, err: 2'b00});
    issueReq(1'b0, 2'd0, 1'b0, 64'h8000_0000, 64'h0, "hold");
    memServe(64'h0000_0000_0000_007F, "hold");
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("hold%0d rsp_valid", i), 64'(reqIf.rsp_valid), 64'd1);
      checkOutput($sformatf("hold%0d rsp_rdata", i), reqIf.rsp_rdata, 64'h7F);
      checkOutput($sformatf("hold%0d req_ready", i), 64'(reqIf.req_ready), 64'd0);
      @(negedge clk);
    end
    popAndCheck("hold");
    consumeRsp("hold");

    // Reset in the middle of WAIT aborts silently.
    issueReq(1'b1, 2'd3, 1'b0, 64'h8000_0018, 64'h1111_2222_3333_4444, "rst");
    memIf.mem_req_ready = 1'b1;
    @(negedge clk);
    memIf.mem_req_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rst req_ready", 64'(reqIf.req_ready), 64'd1);
    checkOutput("rst rsp_valid", 64'(reqIf.rsp_valid), 64'd0);
    checkOutput("rst rsp_err", 64'(reqIf.rsp_err), 64'd0);
    checkOutput("rst mem_req_valid", 64'(memIf.mem_req_valid), 64'd0);
    checkOutput("rst mem_we", 64'(memIf.mem_we), 64'd0);
    checkOutput("rst mem_addr", memIf.mem_addr, 64'd0);
    checkOutput("rst mem_wdata", memIf.mem_wdata, 64'd0);
    checkOutput("rst mem_wmask", 64'(memIf.mem_wmask), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    memIf.mem_rsp_valid = 1'b1;
    memIf.mem_rdata     = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    memIf.mem_rsp_valid = 1'b0;
    checkOutput("rst no response", 64'(reqIf.rsp_valid), 64'd0);
    @(negedge clk);
    checkOutput("rst idle after", 64'(reqIf.req_ready), 64'd1);

    // 32-bit instance: double access is illegal, half load lane extraction on a 4-byte bus.
    checkOutput("x32 req_ready idle", 64'(reqIf32.req_ready), 64'd1);
    reqIf32.req_valid = 1'b1;
    reqIf32.req_size  = 2'd3;
    reqIf32.req_addr  = 32'h0;
    @(negedge clk);
    reqIf32.req_valid = 1'b0;
    checkOutput("x32 LD no mem_req_valid", 64'(memIf32.mem_req_valid), 64'd0);
    checkOutput("x32 LD rsp_valid", 64'(reqIf32.rsp_valid), 64'd1);
    checkOutput("x32 LD rsp_err", 64'(reqIf32.rsp_err), 64'd1);
    reqIf32.rsp_ready = 1'b1;
    @(negedge clk);
    reqIf32.rsp_ready = 1'b0;
    checkOutput("x32 LD rsp_valid cleared", 64'(reqIf32.rsp_valid), 64'd0);
    reqIf32.req_valid = 1'b1;
    reqIf32.req_size  = 2'd1;
    reqIf32.req_addr  = 32'h2;
    @(negedge clk);
    reqIf32.req_valid = 1'b0;
    checkOutput("x32 LH mem_addr", 64'(memIf32.mem_addr), 64'd0);
    checkOutput("x32 LH mem_wmask", 64'(memIf32.mem_wmask), 64'hF);
    memIf32.mem_req_ready = 1'b1;
    @(negedge clk);
    memIf32.mem_req_ready = 1'b0;
    memIf32.mem_rsp_valid = 1'b1;
    memIf32.mem_rdata     = 32'h8001_0000;
    @(negedge clk);
    memIf32.mem_rsp_valid = 1'b0;
    checkOutput("x32 LH rsp_valid", 64'(reqIf32.rsp_valid), 64'd1);
    checkOutput("x32 LH rsp_rdata", 64'(reqIf32.rsp_rdata), 64'hFFFF_8001);
    checkOutput("x32 LH rsp_err", 64'(reqIf32.rsp_err), 64'd0);

    checkOutput("scoreboard drained", 64'(expQ.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/ysyx_22050612_lsu.md
Name: ysyx_22050612_lsu

Overview:
Multi-cycle load/store unit placed between the execute stage and the data-memory port. It replaces the combinational always-on memory read path with a valid/ready transaction that supports the following:
- byte, half, word and double accesses
- store byte masks
- load sign/zero extension
- misalignment detection
- a response timeout

The execute stage stalls while a transaction is outstanding.

Parameters:
XLEN, 64, data/address width; legal values 32 or 64.
TIMEOUT_CYC, 256, maximum cycles spent waiting for a memory response; 0 disables the timeout.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  execute stage presents an access
req_ready  out  1  LSU can accept an access
req_wen  in  1  1 = store, 0 = load
req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double
req_unsigned  in  1  zero-extend a load (LBU/LHU/LWU)
req_addr  in  XLEN  byte address
req_wdata  in  XLEN  store data in the low bytes
rsp_valid  out  1  result available
rsp_ready  in  1  execute stage consumes the result
rsp_rdata  out  XLEN  extended load data; 0 for stores and errors
rsp_err  out  2  00 = ok, 01 = misaligned or illegal size, 10 = timeout
mem_req_valid  out  1  memory request
mem_req_ready  in  1  memory accepts the request
mem_we  out  1  write request
mem_addr  out  XLEN  address aligned to XLEN/8
mem_wdata  out  XLEN  lane-shifted store data
mem_wmask  out  XLEN/8  byte-enable mask
mem_rsp_valid  in  1  read data valid or write acknowledged
mem_rdata  in  XLEN  aligned read word

Behaviour:
- Reset (asynchronous, rst_n low):
  - FSM goes to IDLE.
  - All outputs are 0 except req_ready = 1.
  - Internal request registers and the timeout counter are cleared.
  - Reset during any state aborts the transaction silently; no response is produced.
- FSM states: IDLE, REQ, WAIT, RESP.
- req_ready is 1 only in IDLE.
- IDLE:
  - On req_valid && req_ready, register addr, wdata, size, wen and unsigned.
  - Compute off = addr[log2(XLEN/8)-1:0] and nb = 1<<size.
  - Misaligned is defined as (off & (nb-1)) != 0. Illegal size is size == 3 with XLEN == 32.
  - Misaligned or illegal: go to RESP with err = 01 and no memory access.
  - Otherwise: go to REQ.
- REQ:
  - mem_req_valid = 1.
  - mem_addr = addr with the low log2(XLEN/8) bits cleared.
  - mem_wdata = wdata << (8*off).
  - mem_wmask = ((1<<nb)-1) << off for stores, all ones for loads.
  - mem_we = wen.
  - All outputs stay stable until mem_req_ready; then go to WAIT.
- WAIT:
  - The timeout counter increments each cycle.
  - On mem_rsp_valid:
    - Load: shift = mem_rdata >> (8*off), keep the low 8*nb bits, then sign-extend from bit 8*nb-1 unless unsigned. Size 3 passes through unchanged.
    - Store: rsp_rdata = 0.
    - Go to RESP with err = 00.
  - If TIMEOUT_CYC != 0 and the counter reaches TIMEOUT_CYC-1 without a response, go to RESP with err = 10 and rsp_rdata = 0.
  - mem_rsp_valid arriving in the same cycle as the timeout wins; err = 00.
- RESP:
  - rsp_valid = 1, with rsp_rdata and rsp_err held stable.
  - On rsp_ready go to IDLE and clear rsp_valid.
- mem_rsp_valid is ignored in every state except WAIT, so a late response after a timeout is dropped.
- Best-case load latency: 3 cycles from acceptance to rsp_valid (IDLE → REQ with mem_req_ready = 1 → WAIT with mem_rsp_valid = 1 → RESP).
- Error latency: 1 cycle.
- Only one transaction is outstanding; there is no pipelining.

Decomposition:
- Shared package holds:
  - size encodings SZ_B/SZ_H/SZ_W/SZ_D
  - error codes ERR_OK/ERR_ALIGN/ERR_TIMEOUT
  - FSM state encoding
- One sub-module, ysyx_22050612_lsu_ext: combinational load-lane extraction and sign/zero extension, parametrised by XLEN. It is reused later by the cache refill path.

Test Plan:
1. LB, addr 0x80000003, mem_rdata 0x00000000_8F000000 → mem_addr 0x80000000, rsp_rdata 0xFFFFFFFF_FFFFFF8F, err 00.
2. LWU, addr 0x80000004, mem_rdata 0x80000001_00000000 → rsp_rdata 0x00000000_80000001; the same access with req_unsigned = 0 → 0xFFFFFFFF_80000001.
3. SH, addr 0x80000006, wdata 0x1234 → mem_wdata 0x1234_0000_0000_0000, mem_wmask 0xC0, mem_we 1; after the ack, rsp_rdata 0 and err 00.
4. LD at addr 0x80000004 → no mem_req_valid; rsp_valid one cycle after acceptance with err 01. With XLEN = 32, LD at 0x0 → err 01.
5. mem_req_ready held low for 5 cycles, then mem_rsp_valid withheld with TIMEOUT_CYC = 8 → request fields stable for 5 cycles; err 10 after 8 WAIT cycles. A mem_rsp_valid pulse one cycle later produces no second response.
6. rsp_ready held low for 4 cycles → rsp_valid, rsp_rdata and req_ready = 0 are all held. rst_n dropped mid-WAIT → all outputs 0 and req_ready = 1 immediately.
